gray_seq_ctrl: RTL and testbench

//  Sequencer for the 8-bit binary-to-Gray encoder datapath: holds a binary count, drives it

---
 rtl/gray_seq_pkg.sv | 30 +++
 rtl/gray_seq_ctrl_if.sv | 51 +++++
 rtl/gray_seq_presc.sv | 44 ++++
 rtl/gray_seq_ctrl.sv | 158 +++++++++++++++
 tb/tb_gray_seq_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gray_seq_pkg.sv
// ============================================================================
// Module  : gray_seq_pkg
// Brief   : Shared types, widths and helpers for the Gray-code sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package gray_seq_pkg;

    localparam int GSEQ_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        HOLD = 2'd2,
        RUN  = 2'd3
    } gseq_state_t;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gray_seq_ctrl_if.sv
// ============================================================================
// Module  : gray_seq_ctrl_if
// Brief   : Control, encoder and stream signals of the Gray sequencer.
//           GRAY_CHECK_EN adds the sticky err output.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface gray_seq_ctrl_if;
    import gray_seq_pkg::*;

    logic              start;
    logic              stop;
    logic              up_down;
    logic              load;
    logic [GSEQ_W-1:0] load_val;
    logic [GSEQ_W-1:0] bin_out;
    logic [GSEQ_W-1:0] gray_in;
    logic              out_valid;
    logic              out_ready;
    logic [GSEQ_W-1:0] out_data;
    logic              busy;
    logic              wrap;

`ifdef GRAY_CHECK_EN
    logic              err;

    modport master (
        input  start, stop, up_down, load, load_val, gray_in, out_ready,
        output bin_out, out_valid, out_data, busy, wrap, err
    );

    modport slave (
        output start, stop, up_down, load, load_val, gray_in, out_ready,
        input  bin_out, out_valid, out_data, busy, wrap, err
    );
`else
    modport master (
        input  start, stop, up_down, load, load_val, gray_in, out_ready,
        output bin_out, out_valid, out_data, busy, wrap
    );

    modport slave (
        output start, stop, up_down, load, load_val, gray_in, out_ready,
        input  bin_out, out_valid, out_data, busy, wrap
    );
`endif

endinterface

`default_nettype wire

// File: rtl/gray_seq_presc.sv
// ============================================================================
// Module  : gray_seq_presc
// Brief   : DIV-cycle step prescaler; tick marks the terminal count.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_seq_presc #(
    parameter int DIV = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_clr,
    input  wire logic i_en,
    output logic      o_tick
);

    localparam logic [7:0] c_term = 8'(DIV - 1);

    logic [7:0] presc_q;
    logic [7:0] presc_d;

    always_comb begin
        presc_d = presc_q;
        if (i_clr) begin
            presc_d = 8'd0;
        end else if (i_en) begin
            presc_d = presc_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= 8'd0;
        end else begin
            presc_q <= presc_d;
        end
    end

    assign o_tick = (presc_q == c_term);

endmodule

`default_nettype wire

// File: rtl/gray_seq_ctrl.sv
// ============================================================================
// Module  : gray_seq_ctrl
// Brief   : Binary count sequencer feeding an external Gray encoder and
//           streaming the captured code over valid/ready.
//           Optional macro GRAY_CHECK_EN: sticky err on non-unit-distance words.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_seq_ctrl
    import gray_seq_pkg::*;
#(
    parameter int WIDTH = GSEQ_W,
    parameter int DIV   = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    gray_seq_ctrl_if.master  bus
);

    localparam logic [1:0] c_st_idle = IDLE;
    localparam logic [1:0] c_st_emit = EMIT;
    localparam logic [1:0] c_st_hold = HOLD;
    localparam logic [1:0] c_st_run  = RUN;

    logic [1:0]       state_q,     state_d;
    logic [WIDTH-1:0] count_q,     count_d;
    logic             stop_pend_q, stop_pend_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             wrap_q,      wrap_d;
`ifdef GRAY_CHECK_EN
    logic             err_q,       err_d;
    logic             have_last_q, have_last_d;
`endif

    logic w_tick;
    logic w_presc_clr;

    gray_seq_presc #(.DIV(DIV)) u_presc (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_presc_clr),
        .i_en   (state_q == c_st_run),
        .o_tick (w_tick)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        stop_pend_d = stop_pend_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        wrap_d      = 1'b0;
        w_presc_clr = 1'b0;
`ifdef GRAY_CHECK_EN
        err_d       = err_q;
        have_last_d = have_last_q;
`endif
        case (state_q)
            c_st_idle: begin
                stop_pend_d = 1'b0;
                if (bus.load) begin
                    count_d = bus.load_val;
                end
                if (bus.start) begin
                    state_d = c_st_emit;
`ifdef GRAY_CHECK_EN
                    have_last_d = 1'b0;
`endif
                end
            end
            c_st_emit: begin
                out_data_d  = bus.gray_in;
                out_valid_d = 1'b1;
                state_d     = c_st_hold;
`ifdef GRAY_CHECK_EN
                // out_data_q still holds the previous word of this run
                if (have_last_q && (popcount8(bus.gray_in ^ out_data_q) != 4'd1)) begin
                    err_d = 1'b1;
                end
                have_last_d = 1'b1;
`endif
            end
            c_st_hold: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    w_presc_clr = 1'b1;
                    if (stop_pend_q || bus.stop) begin
                        state_d     = c_st_idle;
                        stop_pend_d = 1'b0;
                    end else begin
                        state_d = c_st_run;
                    end
                end else if (bus.stop) begin
                    stop_pend_d = 1'b1;
                end
            end
            c_st_run: begin
                if (bus.stop) begin
                    state_d     = c_st_idle;
                    stop_pend_d = 1'b0;
                end else if (w_tick) begin
                    w_presc_clr = 1'b1;
                    state_d     = c_st_emit;
                    if (bus.up_down) begin
                        count_d = count_q + 1'b1;
                        wrap_d  = &count_q;
                    end else begin
                        count_d = count_q - 1'b1;
                        wrap_d  = ~|count_q;
                    end
                end
            end
            default: begin
                state_d = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= c_st_idle;
            count_q     <= '0;
            stop_pend_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            wrap_q      <= 1'b0;
`ifdef GRAY_CHECK_EN
            err_q       <= 1'b0;
            have_last_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            stop_pend_q <= stop_pend_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            wrap_q      <= wrap_d;
`ifdef GRAY_CHECK_EN
            err_q       <= err_d;
            have_last_q <= have_last_d;
`endif
        end
    end

    assign bus.bin_out   = count_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = (state_q != c_st_idle);
    assign bus.wrap      = wrap_q;
`ifdef GRAY_CHECK_EN
    assign bus.err       = err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gray_seq_ctrl.sv
// ============================================================================
// Module  : tb_gray_seq_ctrl
// Brief   : Directed bench for gray_seq_ctrl (one DIV=1 and one DIV=4 instance).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gray_seq_ctrl;
    import gray_seq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   force_bad = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    gray_seq_ctrl_if ifc1();
    gray_seq_ctrl_if ifc4();

    // Reference encoder; ifc4 can be forced to a bad code
    assign ifc1.gray_in = ifc1.bin_out ^ (ifc1.bin_out >> 1);
    assign ifc4.gray_in = force_bad ? 8'h03 : (ifc4.bin_out ^ (ifc4.bin_out >> 1));

    gray_seq_ctrl #(.WIDTH(8), .DIV(1)) u_dut1 (.clk(clk), .rst(rst), .bus(ifc1.master));
    gray_seq_ctrl #(.WIDTH(8), .DIV(4)) u_dut4 (.clk(clk), .rst(rst), .bus(ifc4.master));

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ifc1.start = 0; ifc1.stop = 0; ifc1.up_down = 1; ifc1.load = 0;
        ifc1.load_val = 8'h00; ifc1.out_ready = 0;
        ifc4.start = 0; ifc4.stop = 0; ifc4.up_down = 1; ifc4.load = 0;
        ifc4.load_val = 8'h00; ifc4.out_ready = 0;
        force_bad = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic start4(input logic [7:0] val, input logic up, input logic rdy);
        @(negedge clk);
        ifc4.load = 1; ifc4.load_val = val; ifc4.start = 1;
        ifc4.up_down = up; ifc4.out_ready = rdy;
        @(negedge clk);
        ifc4.load = 0; ifc4.start = 0;
    endtask

    // Returns at the negedge where a word is about to be accepted
    task automatic get_word4(output logic [7:0] w, output bit ok);
        ok = 1'b0;
        w  = 8'h00;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ifc4.out_valid && ifc4.out_ready) begin
                w  = ifc4.out_data;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_valid4(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ifc4.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (ifc4.out_valid !== 1'b0 || ifc4.busy !== 1'b0 || ifc4.wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: valid=%b busy=%b wrap=%b, required 0 0 0",
                     ifc4.out_valid, ifc4.busy, ifc4.wrap);
        end
        n_tests++;
        if (ifc4.out_data !== 8'h00 || ifc4.bin_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data: out_data=%h bin_out=%h, required 00 00",
                     ifc4.out_data, ifc4.bin_out);
        end
    endtask

    task automatic test_div1_up();
        logic [7:0] exp_w [5];
        logic [7:0] w;
        bit         got;
        int         gap;
        exp_w = '{8'h00, 8'h01, 8'h03, 8'h02, 8'h06};
        do_reset();
        @(negedge clk);
        ifc1.load = 1; ifc1.load_val = 8'h00; ifc1.start = 1;
        ifc1.up_down = 1; ifc1.out_ready = 1;
        @(negedge clk);
        ifc1.load = 0; ifc1.start = 0;
        for (int k = 0; k < 5; k++) begin
            got = 1'b0; gap = 0; w = 8'h00;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                gap++;
                if (ifc1.out_valid && ifc1.out_ready) begin
                    got = 1'b1;
                    w   = ifc1.out_data;
                end
            end
            n_tests++;
            if (!got || w !== exp_w[k]) begin
                n_fail++;
                $display("FAIL div1_word%0d: got=%b data=%h, required %h", k, got, w, exp_w[k]);
            end
            if (k > 0) begin
                n_tests++;
                if (gap != 3) begin
                    n_fail++;
                    $display("FAIL div1_rate%0d: gap=%0d cycles, required 3", k, gap);
                end
            end
        end
        ifc1.stop = 1;
        @(negedge clk);
        ifc1.stop = 0;
    endtask

    task automatic test_down_wrap();
        logic [7:0] w;
        bit         ok;
        int         wraps;
        do_reset();
        start4(8'h00, 1'b0, 1'b1);
        ok = 1'b0;
        wraps = 0;
        w = 8'h00;
        // the start negedge already counts as the first poll window
        if (ifc4.out_valid) begin ok = 1'b1; w = ifc4.out_data; end
        else get_word4(w, ok);
        n_tests++;
        if (!ok || w !== 8'h00) begin
            n_fail++;
            $display("FAIL down_first: got=%b data=%h, required 00", ok, w);
        end
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            if (ifc4.wrap) wraps++;
            if (ifc4.out_valid && ifc4.out_ready) begin
                ok = 1'b1;
                w  = ifc4.out_data;
            end
        end
        n_tests++;
        if (!ok || w !== 8'h80 || ifc4.bin_out !== 8'hFF) begin
            n_fail++;
            $display("FAIL down_word: data=%h count=%h, required 80 FF", w, ifc4.bin_out);
        end
        n_tests++;
        if (wraps != 1) begin
            n_fail++;
            $display("FAIL down_wrap: wrap high %0d cycles, required 1", wraps);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] w;
        bit         ok;
        int         bad;
        do_reset();
        start4(8'h7F, 1'b1, 1'b0);
        wait_valid4(ok);
        bad = ok ? 0 : 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ifc4.out_valid !== 1'b1 || ifc4.out_data !== 8'h40) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL hold_stable: %0d bad cycles, last valid=%b data=%h, required 1 40",
                     bad, ifc4.out_valid, ifc4.out_data);
        end
        ifc4.out_ready = 1;
        get_word4(w, ok);
        n_tests++;
        if (!ok || w !== 8'hC0) begin
            n_fail++;
            $display("FAIL hold_next: got=%b data=%h, required C0", ok, w);
        end
    endtask

    task automatic test_stop_in_hold();
        bit ok;
        int bad;
        int words;
        do_reset();
        start4(8'h05, 1'b1, 1'b0);
        wait_valid4(ok);
        ifc4.stop = 1;
        @(negedge clk);
        ifc4.stop = 0;
        bad = ok ? 0 : 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ifc4.busy !== 1'b1 || ifc4.out_valid !== 1'b1) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL stop_stays_hold: %0d bad cycles, busy=%b valid=%b, required 1 1",
                     bad, ifc4.busy, ifc4.out_valid);
        end
        ifc4.out_ready = 1;
        @(negedge clk);
        n_tests++;
        if (ifc4.busy !== 1'b0 || ifc4.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_idle: busy=%b valid=%b, required 0 0", ifc4.busy, ifc4.out_valid);
        end
        words = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ifc4.out_valid) words++;
        end
        n_tests++;
        if (words != 0) begin
            n_fail++;
            $display("FAIL stop_no_word: %0d valid cycles after stop, required 0", words);
        end
    endtask

    task automatic test_reset_in_run();
        logic [7:0] w;
        bit         ok;
        do_reset();
        start4(8'h10, 1'b1, 1'b1);
        if (ifc4.out_valid) begin ok = 1'b1; w = ifc4.out_data; end
        else get_word4(w, ok);
        n_tests++;
        if (!ok || w !== 8'h18) begin
            n_fail++;
            $display("FAIL rrun_word: got=%b data=%h, required 18", ok, w);
        end
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if (ifc4.out_valid !== 1'b0 || ifc4.busy !== 1'b0 || ifc4.wrap !== 1'b0 ||
            ifc4.out_data !== 8'h00 || ifc4.bin_out !== 8'h00) begin
            n_fail++;
            $display("FAIL rrun_reset: valid=%b busy=%b wrap=%b data=%h count=%h, required 0 0 0 00 00",
                     ifc4.out_valid, ifc4.busy, ifc4.wrap, ifc4.out_data, ifc4.bin_out);
        end
        ifc4.start = 1;
        @(negedge clk);
        ifc4.start = 0;
        get_word4(w, ok);
        n_tests++;
        if (!ok || w !== 8'h00) begin
            n_fail++;
            $display("FAIL rrun_restart: got=%b data=%h, required 00", ok, w);
        end
    endtask

`ifdef GRAY_CHECK_EN
    task automatic test_gray_check();
        logic [7:0] w;
        bit         ok;
        do_reset();
        start4(8'h00, 1'b1, 1'b1);
        if (ifc4.out_valid) begin ok = 1'b1; w = ifc4.out_data; end
        else get_word4(w, ok);
        n_tests++;
        if (!ok || ifc4.err !== 1'b0) begin
            n_fail++;
            $display("FAIL chk_clean: got=%b err=%b, required err 0", ok, ifc4.err);
        end
        force_bad = 1'b1;
        get_word4(w, ok);
        force_bad = 1'b0;
        n_tests++;
        if (!ok || w !== 8'h03 || ifc4.err !== 1'b1) begin
            n_fail++;
            $display("FAIL chk_flag: data=%h err=%b, required 03 1", w, ifc4.err);
        end
        ifc4.stop = 1;
        @(negedge clk);
        ifc4.stop = 0;
        repeat (10) @(negedge clk);
        n_tests++;
        if (ifc4.err !== 1'b1) begin
            n_fail++;
            $display("FAIL chk_sticky: err=%b, required 1", ifc4.err);
        end
        do_reset();
        n_tests++;
        if (ifc4.err !== 1'b0) begin
            n_fail++;
            $display("FAIL chk_rst: err=%b, required 0", ifc4.err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_div1_up();
        test_down_wrap();
        test_backpressure();
        test_stop_in_hold();
        test_reset_in_run();
`ifdef GRAY_CHECK_EN
        test_gray_check();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
